// File: rtl/lmb_bram_arb_pkg.sv
// rtl/lmb_bram_arb_pkg.sv - shared types and helpers for the LMB BRAM port arbiter
package lmb_bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  // One extra bit so the counter can hold C_MAX_LOCK itself.
  function automatic int lock_cnt_w(input int max_lock);
    return $clog2(max_lock) + 1;
  endfunction

endpackage

// File: rtl/lmb_bram_port_arbiter_if.sv
// rtl/lmb_bram_port_arbiter_if.sv - requester and BRAM port B signal bundle
interface lmb_bram_port_arbiter_if #(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4
);
  logic                     Req_0;
  logic                     Req_1;
  logic                     Lock_0;
  logic                     Lock_1;
  logic [C_PORT_AWIDTH-1:0] Addr_0;
  logic [C_PORT_AWIDTH-1:0] Addr_1;
  logic [C_NUM_WE-1:0]      WEN_0;
  logic [C_NUM_WE-1:0]      WEN_1;
  logic [C_PORT_DWIDTH-1:0] WrData_0;
  logic [C_PORT_DWIDTH-1:0] WrData_1;
  logic                     Ack_0;
  logic                     Ack_1;
  logic                     RdValid_0;
  logic                     RdValid_1;
  logic [C_PORT_DWIDTH-1:0] RdData;
  logic                     BRAM_EN;
  logic [C_NUM_WE-1:0]      BRAM_WEN;
  logic [C_PORT_AWIDTH-1:0] BRAM_Addr;
  logic [C_PORT_DWIDTH-1:0] BRAM_Dout;
  logic [C_PORT_DWIDTH-1:0] BRAM_Din;

  modport slave (
    input  Req_0, Req_1, Lock_0, Lock_1, Addr_0, Addr_1, WEN_0, WEN_1,
           WrData_0, WrData_1, BRAM_Din,
    output Ack_0, Ack_1, RdValid_0, RdValid_1, RdData,
           BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
  );

  modport master (
    output Req_0, Req_1, Lock_0, Lock_1, Addr_0, Addr_1, WEN_0, WEN_1,
           WrData_0, WrData_1, BRAM_Din,
    input  Ack_0, Ack_1, RdValid_0, RdValid_1, RdData,
           BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
  );

endinterface

// File: rtl/lmb_bram_rr_pick.sv
// rtl/lmb_bram_rr_pick.sv - combinational two-way round-robin selector
module lmb_bram_rr_pick
  import lmb_bram_arb_pkg::*;
(
  input  logic [1:0] i_elig,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_elig[REQ0] && i_elig[REQ1]) begin
      o_grant[REQ0] = ~i_ptr;
      o_grant[REQ1] = i_ptr;
    end else begin
      o_grant = i_elig;
    end
  end

endmodule

// File: rtl/lmb_bram_port_arbiter.sv
// rtl/lmb_bram_port_arbiter.sv - round-robin arbiter with locked bursts sharing one BRAM port
module lmb_bram_port_arbiter
  import lmb_bram_arb_pkg::*;
#(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_MAX_LOCK    = 16
) (
  input logic                    BRAM_Clk,
  input logic                    BRAM_Rst,
  lmb_bram_port_arbiter_if.slave bus
);

  localparam int              CW      = lock_cnt_w(C_MAX_LOCK);
  localparam logic [CW-1:0]   MAX_CNT = CW'(C_MAX_LOCK);

  arb_state_t               r_state;
  logic                     r_ptr;
  logic [CW-1:0]            r_cnt;
  logic                     r_ack_0;
  logic                     r_ack_1;
  logic                     r_rdvalid_0;
  logic                     r_rdvalid_1;
  logic                     r_en;
  logic [C_NUM_WE-1:0]      r_wen;
  logic [C_PORT_AWIDTH-1:0] r_addr;
  logic [C_PORT_DWIDTH-1:0] r_dout;

  logic [1:0]               w_elig;
  logic [1:0]               w_pick_elig;
  logic [1:0]               w_pick;
  logic [1:0]               w_grant;
  logic                     w_own;
  logic                     w_own_idx;
  logic                     w_own_req;
  logic                     w_own_ack;
  logic                     w_handover;
  logic                     w_ptr_eff;
  logic                     w_gvalid;
  logic                     w_gidx;
  logic                     w_glock;
  logic [C_NUM_WE-1:0]      w_gwen;
  logic [C_PORT_AWIDTH-1:0] w_gaddr;
  logic [C_PORT_DWIDTH-1:0] w_gdata;

  // A requester being acknowledged this cycle must not be granted again.
  assign w_elig[REQ0] = bus.Req_0 & ~r_ack_0;
  assign w_elig[REQ1] = bus.Req_1 & ~r_ack_1;

  assign w_own      = (r_state != ST_IDLE);
  assign w_own_idx  = (r_state == ST_OWN1);
  assign w_own_req  = w_own_idx ? bus.Req_1 : bus.Req_0;
  assign w_own_ack  = w_own_idx ? r_ack_1 : r_ack_0;
  assign w_handover = w_own & ((r_cnt >= MAX_CNT) | (~w_own_req & ~w_own_ack));

  // On hand-over the other requester may be served in the same cycle.
  assign w_ptr_eff   = w_handover ? ~w_own_idx : r_ptr;
  assign w_pick_elig = w_handover ? (w_own_idx ? (w_elig & 2'b01) : (w_elig & 2'b10))
                                  : w_elig;

  lmb_bram_rr_pick u_pick (
    .i_elig  (w_pick_elig),
    .i_ptr   (w_ptr_eff),
    .o_grant (w_pick)
  );

  always_comb begin
    w_grant = 2'b00;
    if (!w_own || w_handover) begin
      w_grant = w_pick;
    end else if (w_elig[w_own_idx]) begin
      w_grant = w_own_idx ? 2'b10 : 2'b01;
    end
  end

  assign w_gvalid = |w_grant;
  assign w_gidx   = w_grant[REQ1];
  assign w_glock  = w_gidx ? bus.Lock_1   : bus.Lock_0;
  assign w_gwen   = w_gidx ? bus.WEN_1    : bus.WEN_0;
  assign w_gaddr  = w_gidx ? bus.Addr_1   : bus.Addr_0;
  assign w_gdata  = w_gidx ? bus.WrData_1 : bus.WrData_0;

  always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
    if (BRAM_Rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_cnt       <= '0;
      r_ack_0     <= 1'b0;
      r_ack_1     <= 1'b0;
      r_rdvalid_0 <= 1'b0;
      r_rdvalid_1 <= 1'b0;
      r_en        <= 1'b0;
      r_wen       <= '0;
      r_addr      <= '0;
      r_dout      <= '0;
    end else begin
      r_en        <= w_gvalid;
      r_ack_0     <= w_grant[REQ0];
      r_ack_1     <= w_grant[REQ1];
      r_wen       <= w_gvalid ? w_gwen : '0;
      // Read data arrives one cycle after the command is on the pins.
      r_rdvalid_0 <= r_ack_0 && (r_wen == '0);
      r_rdvalid_1 <= r_ack_1 && (r_wen == '0);
      if (w_gvalid) begin
        r_addr <= w_gaddr;
        r_dout <= w_gdata;
      end

      if (w_own && !w_handover) begin
        if (w_gvalid) begin
          if (w_glock) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= ~w_own_idx;
          end
        end
      end else if (w_gvalid) begin
        r_ptr <= ~w_gidx;
        if (w_glock) begin
          r_state <= w_gidx ? ST_OWN1 : ST_OWN0;
          r_cnt   <= CW'(1);
        end else begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      end else if (w_handover) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_ptr   <= ~w_own_idx;
      end
    end
  end

  assign bus.Ack_0     = r_ack_0;
  assign bus.Ack_1     = r_ack_1;
  assign bus.RdValid_0 = r_rdvalid_0;
  assign bus.RdValid_1 = r_rdvalid_1;
  assign bus.RdData    = bus.BRAM_Din;
  assign bus.BRAM_EN   = r_en;
  assign bus.BRAM_WEN  = r_wen;
  assign bus.BRAM_Addr = r_addr;
  assign bus.BRAM_Dout = r_dout;

endmodule

// File: tb/tb_lmb_bram_port_arbiter.sv
// tb/tb_lmb_bram_port_arbiter.sv - scoreboard bench for lmb_bram_port_arbiter
module tb_lmb_bram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lmb_bram_port_arbiter_if #(.C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4)) bus ();

  lmb_bram_port_arbiter #(
    .C_PORT_DWIDTH (32),
    .C_PORT_AWIDTH (32),
    .C_NUM_WE      (4),
    .C_MAX_LOCK    (16)
  ) dut (
    .BRAM_Clk (clk),
    .BRAM_Rst (rst),
    .bus      (bus)
  );

  typedef struct {
    int          req;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } grant_t;

  typedef struct {
    int          req;
    logic [31:0] data;
  } rd_t;

  grant_t gq[$];
  rd_t    rq[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int ack_first[2] = '{-1, -1};
  int ack_last[2]  = '{-1, -1};
  int rdv_last[2]  = '{-1, -1};
  int     m_r;
  grant_t m_g;
  rd_t    m_d;
  int     t0;

  // Untouched words read back as 0xA500_0000 | byte address.
  logic [31:0] mem [0:1023];
  bit   [1023:0] wr_mark;

  always @(posedge clk) begin
    cyc++;
    if (bus.BRAM_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.BRAM_WEN[b]) begin
          mem[bus.BRAM_Addr[11:2]][8*b +: 8] <= bus.BRAM_Dout[8*b +: 8];
        end
      end
      if (bus.BRAM_WEN != 4'h0) wr_mark[bus.BRAM_Addr[11:2]] <= 1'b1;
      bus.BRAM_Din <= wr_mark[bus.BRAM_Addr[11:2]] ? mem[bus.BRAM_Addr[11:2]]
                    : (32'hA500_0000 | {20'h0, bus.BRAM_Addr[11:2], 2'b00});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.BRAM_EN) en_cnt++;
    if (bus.Ack_0 && bus.Ack_1) begin
      chk("ack_onehot", {bus.Ack_1, bus.Ack_0}, 32'h1);
    end else if (bus.Ack_0 || bus.Ack_1) begin
      m_r = bus.Ack_1 ? 1 : 0;
      if (ack_first[m_r] < 0) ack_first[m_r] = cyc;
      ack_last[m_r] = cyc;
      if (gq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_ack: requester %0d addr %h, expected no grant", m_r, bus.BRAM_Addr);
      end else begin
        m_g = gq.pop_front();
        chk("grant_req", m_r, m_g.req);
        chk("grant_addr", bus.BRAM_Addr, m_g.addr);
        chk("grant_wen", {28'h0, bus.BRAM_WEN}, {28'h0, m_g.wen});
        chk("grant_en", {31'h0, bus.BRAM_EN}, 32'h1);
        if (m_g.wen != 4'h0) chk("grant_dout", bus.BRAM_Dout, m_g.data);
      end
    end
    if (bus.RdValid_0 && bus.RdValid_1) begin
      chk("rdv_onehot", {bus.RdValid_1, bus.RdValid_0}, 32'h1);
    end else if (bus.RdValid_0 || bus.RdValid_1) begin
      m_r = bus.RdValid_1 ? 1 : 0;
      rdv_last[m_r] = cyc;
      if (rq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rdvalid: requester %0d data %h, expected none", m_r, bus.RdData);
      end else begin
        m_d = rq.pop_front();
        chk("rd_req", m_r, m_d.req);
        chk("rd_data", bus.RdData, m_d.data);
      end
    end
  end

  task automatic set_req(input int idx, input logic req, input logic lock,
                         input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    if (idx == 0) begin
      bus.Req_0 = req; bus.Lock_0 = lock; bus.Addr_0 = addr; bus.WEN_0 = wen; bus.WrData_0 = data;
    end else begin
      bus.Req_1 = req; bus.Lock_1 = lock; bus.Addr_1 = addr; bus.WEN_1 = wen; bus.WrData_1 = data;
    end
  endtask

  task automatic wait_ack(input int idx);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = (idx == 0) ? bus.Ack_0 : bus.Ack_1;
    end
    n_checks++;
    if (!got) begin
      n_err++;
      $display("FAIL ack_timeout: requester %0d got no Ack, required one within 200 cycles", idx);
    end
  endtask

  task automatic drive(input int idx, input int n, input logic [31:0] base, input logic [3:0] wen,
                       input logic [31:0] wdata, input int lock_n);
    for (int k = 0; k < n; k++) begin
      set_req(idx, 1'b1, (k < lock_n), base + 32'(4 * k), wen, wdata + 32'(k));
      wait_ack(idx);
    end
    set_req(idx, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic exp_rd(input int idx, input logic [31:0] addr, input logic [31:0] data);
    gq.push_back('{req: idx, addr: addr, wen: 4'h0, data: 32'h0});
    rq.push_back('{req: idx, data: data});
  endtask

  task automatic clear_stats();
    en_cnt    = 0;
    ack_first = '{-1, -1};
    ack_last  = '{-1, -1};
    rdv_last  = '{-1, -1};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic drain(input string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_grants_left"}, gq.size(), 0);
    chk({tag, "_reads_left"}, rq.size(), 0);
    gq.delete();
    rq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, {31'h0, bus.BRAM_EN}, 32'h0);
    chk({tag, "_wen"}, {28'h0, bus.BRAM_WEN}, 32'h0);
    chk({tag, "_addr"}, bus.BRAM_Addr, 32'h0);
    chk({tag, "_dout"}, bus.BRAM_Dout, 32'h0);
    chk({tag, "_ack"}, {30'h0, bus.Ack_1, bus.Ack_0}, 32'h0);
    chk({tag, "_rdv"}, {30'h0, bus.RdValid_1, bus.RdValid_0}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

  initial begin
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    clear_stats();

    // Single read
    @(negedge clk);
    t0 = cyc;
    exp_rd(0, 32'h10, 32'hA500_0010);
    drive(0, 1, 32'h10, 4'h0, 32'h0, 0);
    drain("single_read");
    chk("single_ack_latency", ack_first[0] - t0, 1);
    chk("single_rdv_latency", rdv_last[0] - t0, 2);

    // Write then read-back on requester 1
    gq.push_back('{req: 1, addr: 32'h20, wen: 4'hF, data: 32'hDEAD_BEEF});
    exp_rd(1, 32'h20, 32'hDEAD_BEEF);
    set_req(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'hDEAD_BEEF);
    wait_ack(1);
    set_req(1, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    wait_ack(1);
    set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drain("wr_rd");
    chk("idle_en", {31'h0, bus.BRAM_EN}, 32'h0);
    chk("idle_wen", {28'h0, bus.BRAM_WEN}, 32'h0);
    chk("idle_addr_hold", bus.BRAM_Addr, 32'h20);

    // Contention: strict alternation, port busy every cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      exp_rd(0, 32'h100 + 32'(4 * k), 32'hA500_0100 + 32'(4 * k));
      exp_rd(1, 32'h200 + 32'(4 * k), 32'hA500_0200 + 32'(4 * k));
    end
    fork
      drive(0, 8, 32'h100, 4'h0, 32'h0, 0);
      drive(1, 8, 32'h200, 4'h0, 32'h0, 0);
    join
    drain("contend");
    chk("contend_en_cycles", en_cnt, 16);
    chk("contend_span", ack_last[1] - ack_first[0], 15);

    // Locked burst hits the 16-grant limit
    do_reset();
    for (int k = 0; k < 16; k++) exp_rd(0, 32'h300 + 32'(4 * k), 32'hA500_0300 + 32'(4 * k));
    exp_rd(1, 32'h400, 32'hA500_0400);
    for (int k = 16; k < 20; k++) exp_rd(0, 32'h300 + 32'(4 * k), 32'hA500_0300 + 32'(4 * k));
    fork
      drive(0, 20, 32'h300, 4'h0, 32'h0, 20);
      drive(1, 1, 32'h400, 4'h0, 32'h0, 0);
    join
    drain("lock_burst");

    // Lock released on the fourth grant
    do_reset();
    for (int k = 0; k < 4; k++) exp_rd(0, 32'h500 + 32'(4 * k), 32'hA500_0500 + 32'(4 * k));
    exp_rd(1, 32'h600, 32'hA500_0600);
    exp_rd(1, 32'h604, 32'hA500_0604);
    fork
      drive(0, 4, 32'h500, 4'h0, 32'h0, 3);
      drive(1, 2, 32'h600, 4'h0, 32'h0, 0);
    join
    drain("lock_release");
    chk("release_handover_gap", ack_first[1] - ack_last[0], 1);

    // Reset between Ack and RdValid
    do_reset();
    gq.push_back('{req: 0, addr: 32'h40, wen: 4'h0, data: 32'h0});
    set_req(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    wait_ack(0);
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    repeat (3) @(negedge clk);
    chk("reset_dropped_rdv", rdv_last[0], -1);
    rst = 1'b0;
    clear_stats();
    exp_rd(0, 32'h44, 32'hA500_0044);
    exp_rd(1, 32'h48, 32'hA500_0048);
    fork
      drive(0, 1, 32'h44, 4'h0, 32'h0, 0);
      drive(1, 1, 32'h48, 4'h0, 32'h0, 0);
    join
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
